ifetch_queue: RTL and testbench

Registered instruction-fetch unit with a prefetch FIFO. It replaces the combinational fetch stage between the core's PC logic and the instruction ROM bus. The unit owns its own fetch PC, issues sequential word reads to a synchronous ROM, and buffers up to DEPTH instructions with their PCs and fault flags. It supports redirect (branch/trap) with flush of queued and in-flight fetches.

---
 rtl/ifetch_queue_if.sv | 43 ++++
 rtl/ifetch_queue.sv | 143 ++++++++++++++
 tb/tb_ifetch_queue.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if
//   Bundles the fetch unit's redirect input, ROM read bus and instruction
//   stream into one interface.
//
//   Signals:
//     redirect, redirect_pc       flush request and new fetch address
//     ibus_rd_en, ibus_rd_addr    ROM read strobe and word address
//     ibus_rd_data                ROM data, one cycle after the strobe
//     inst_valid, inst_ready      instruction stream handshake
//     inst, inst_pc               head instruction and its PC
//     access_fault, misaligned    head entry fault flags
//
//   Modports:
//     master  the fetch unit (drives the ROM strobe and the stream)
//     slave   the surrounding core/ROM side
interface ifetch_queue_if #(
    parameter int WIDTH          = 32,
    parameter int ROM_ADDR_WIDTH = 10
);
    logic                      redirect;
    logic [WIDTH-1:0]          redirect_pc;
    logic                      ibus_rd_en;
    logic [ROM_ADDR_WIDTH-1:0] ibus_rd_addr;
    logic [WIDTH-1:0]          ibus_rd_data;
    logic                      inst_valid;
    logic                      inst_ready;
    logic [WIDTH-1:0]          inst;
    logic [WIDTH-1:0]          inst_pc;
    logic                      access_fault;
    logic                      misaligned;

    modport master (
        input  redirect, redirect_pc, ibus_rd_data, inst_ready,
        output ibus_rd_en, ibus_rd_addr, inst_valid, inst, inst_pc,
               access_fault, misaligned
    );

    modport slave (
        output redirect, redirect_pc, ibus_rd_data, inst_ready,
        input  ibus_rd_en, ibus_rd_addr, inst_valid, inst, inst_pc,
               access_fault, misaligned
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue
//   Registered instruction-fetch unit with a prefetch FIFO. Owns the fetch
//   PC, issues sequential word reads to a synchronous ROM (1-cycle latency)
//   and buffers up to DEPTH {instruction, pc, access_fault, misaligned}
//   entries. A redirect flushes queued and in-flight fetches and restarts at
//   redirect_pc. A PC outside the ROM (or misaligned, when enabled) produces
//   a single fault entry, after which the unit halts until the next redirect.
//
//   Ports:
//     clk    clock, all logic on the rising edge
//     rst_n  synchronous active-low reset
//     bus    ifetch_queue_if.master (redirect, ROM read bus, inst stream)
//
//   Configuration macro:
//     IFETCH_MISALIGN_EN  when defined, pc[1:0] != 0 is a fault (misaligned
//                         flag). When undefined, pc[1:0] are ignored for
//                         addressing and misaligned is always 0.
module ifetch_queue #(
    parameter int               WIDTH          = 32,
    parameter int               ROM_ADDR_WIDTH = 10,
    parameter int               DEPTH          = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR     = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    ifetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     fetch_pc;
    logic [WIDTH-1:0]     issued_pc;
    logic                 inflight;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic [WIDTH-1:0]     q_inst [DEPTH];
    logic [WIDTH-1:0]     q_pc   [DEPTH];
    logic                 q_af   [DEPTH];
    logic                 q_mis  [DEPTH];

    logic                 pc_af;
    logic                 pc_mis;
    logic                 pc_fault;
    logic                 issue;
    logic                 fault_push;
    logic                 resp_push;
    logic                 push;
    logic                 pop;
    logic                 head_valid;

    // Fault classification of the current fetch PC and the per-cycle
    // issue/push/pop decisions. Redirect overrides everything. The issue
    // check looks only at the registered count, so a slot freed by a pop in
    // this cycle is not refilled by a read issued in the same cycle; that
    // keeps count + inflight <= DEPTH, so a response always finds room.
    always_comb begin
        pc_af = |fetch_pc[WIDTH-1:ROM_ADDR_WIDTH+2];
`ifdef IFETCH_MISALIGN_EN
        pc_mis = |fetch_pc[1:0];
`else
        pc_mis = 1'b0;
`endif
        pc_fault   = pc_af | pc_mis;
        head_valid = (count != '0);

        issue = rst_n && !bus.redirect && (state == ST_RUN) && !pc_fault
                && ((count + CNT_W'(inflight)) < CNT_W'(DEPTH));

        // A fault entry waits for the bus to be idle so it lands behind the
        // last legal response, and for a free slot.
        fault_push = !bus.redirect && (state == ST_RUN) && pc_fault
                     && !inflight && (count < CNT_W'(DEPTH));

        resp_push = inflight && !bus.redirect;
        push      = resp_push | fault_push;
        pop       = head_valid && bus.inst_ready && !bus.redirect;
    end

    // Control state: fetch PC, in-flight tracking, FIFO pointers and the
    // RUN/HALT state machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            fetch_pc  <= RESET_ADDR;
            issued_pc <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else if (bus.redirect) begin
            state    <= ST_RUN;
            fetch_pc <= bus.redirect_pc;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                issued_pc <= fetch_pc;
                fetch_pc  <= fetch_pc + WIDTH'(4);
            end
            if (fault_push) begin
                state <= ST_HALT;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage. Entries carry no reset; the head outputs are masked to
    // zero while the FIFO is empty instead.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            q_inst[wr_ptr] <= fault_push ? '0 : bus.ibus_rd_data;
            q_pc[wr_ptr]   <= fault_push ? fetch_pc : issued_pc;
            q_af[wr_ptr]   <= fault_push & pc_af;
            q_mis[wr_ptr]  <= fault_push & pc_mis;
        end
    end

    assign bus.ibus_rd_en   = issue;
    assign bus.ibus_rd_addr = fetch_pc[ROM_ADDR_WIDTH+1:2];

    assign bus.inst_valid   = head_valid;
    assign bus.inst         = head_valid ? q_inst[rd_ptr] : '0;
    assign bus.inst_pc      = head_valid ? q_pc[rd_ptr]   : '0;
    assign bus.access_fault = head_valid & q_af[rd_ptr];
    assign bus.misaligned   = head_valid & q_mis[rd_ptr];
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue
//   Self-checking bench for ifetch_queue. A synchronous ROM model returns
//   ~(byte address) for every word. Directed vectors cover reset, start-up
//   latency, stall and release; hand-written sequences cover flush, access
//   fault, misaligned PC and reset while full; a randomized phase checks the
//   fetched stream against an instruction-stream reference model.
module tb_ifetch_queue;
    localparam int WIDTH = 32;
    localparam int RAW   = 10;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    ifetch_queue_if #(.WIDTH(WIDTH), .ROM_ADDR_WIDTH(RAW)) bus ();

    ifetch_queue #(
        .WIDTH(WIDTH),
        .ROM_ADDR_WIDTH(RAW),
        .DEPTH(DEPTH),
        .RESET_ADDR(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: word at byte address A holds ~A.
    always_ff @(posedge clk) begin
        if (bus.ibus_rd_en) begin
            bus.ibus_rd_data <= ~{20'h0, bus.ibus_rd_addr, 2'b00};
        end
    end

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        exp_rd_en;
        logic [9:0]  exp_addr;
        logic        exp_valid;
        logic        chk_head;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vq[$];

    // Drive one cycle of inputs at the falling edge, then settle.
    task automatic applyStimulus(input logic r, input logic redir,
                                 input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rst_n           = r;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.inst_ready  = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkHead(input string tag, input logic [31:0] i,
                             input logic [31:0] pc, input logic af,
                             input logic mis);
        checkOutput({tag, "_valid"}, bus.inst_valid, 1'b1);
        checkOutput({tag, "_inst"}, bus.inst, i);
        checkOutput({tag, "_pc"}, bus.inst_pc, pc);
        checkOutput({tag, "_af"}, bus.access_fault, af);
        checkOutput({tag, "_mis"}, bus.misaligned, mis);
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, "_valid"}, bus.inst_valid, 1'b0);
        checkOutput({tag, "_inst"}, bus.inst, 32'h0);
        checkOutput({tag, "_pc"}, bus.inst_pc, 32'h0);
        checkOutput({tag, "_af"}, bus.access_fault, 1'b0);
        checkOutput({tag, "_mis"}, bus.misaligned, 1'b0);
    endtask

    task automatic addVec(input logic r, input logic rdy, input logic en,
                          input logic [9:0] a, input logic v, input logic c,
                          input logic [31:0] i, input logic [31:0] pc);
        vec_t x;
        x.rst_n = r;   x.ready = rdy; x.exp_rd_en = en; x.exp_addr = a;
        x.exp_valid = v; x.chk_head = c; x.exp_inst = i; x.exp_pc = pc;
        vq.push_back(x);
    endtask

    // Reference rules: the ROM covers byte addresses below 0x1000.
    function automatic logic isAf(input logic [31:0] pc);
        return pc >= 32'h1000;
    endfunction

    function automatic logic isMis(input logic [31:0] pc);
`ifdef IFETCH_MISALIGN_EN
        return (pc % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] pickTarget();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel < 4)      return $urandom_range(0, 1023) * 4;
        else if (sel < 6) return 32'h1000 - 4 * $urandom_range(1, 6);
        else if (sel < 7) return (32'h1000 << $urandom_range(0, 19)) | ($urandom & 32'hFFC);
        else if (sel < 9) return $urandom_range(0, 1023) * 4 + $urandom_range(1, 3);
        else              return 32'h0;
    endfunction

    initial begin
        logic [31:0] mFetch;
        logic [31:0] mPop;
        int          outstanding;
        bit          halted;
        int          idle;
        int          pops;

        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready  = 1'b0;

        // ---------------- directed vector table ----------------
        //      rst rdy en  addr   valid chk inst          pc
        addVec(0, 1, 0, 10'd0, 0, 1, 32'h0,        32'h0);
        addVec(0, 1, 0, 10'd0, 0, 1, 32'h0,        32'h0);
        addVec(1, 1, 1, 10'd0, 0, 1, 32'h0,        32'h0);
        addVec(1, 1, 1, 10'd1, 0, 0, 32'h0,        32'h0);
        addVec(1, 1, 1, 10'd2, 1, 1, 32'hFFFFFFFF, 32'h0);
        addVec(1, 1, 1, 10'd3, 1, 1, 32'hFFFFFFFB, 32'h4);
        addVec(1, 0, 1, 10'd4, 1, 1, 32'hFFFFFFF7, 32'h8);
        addVec(1, 0, 1, 10'd5, 1, 1, 32'hFFFFFFF7, 32'h8);
        addVec(1, 0, 0, 10'd6, 1, 1, 32'hFFFFFFF7, 32'h8);
        addVec(1, 0, 0, 10'd6, 1, 1, 32'hFFFFFFF7, 32'h8);
        addVec(1, 1, 0, 10'd6, 1, 1, 32'hFFFFFFF7, 32'h8);
        addVec(1, 1, 1, 10'd6, 1, 1, 32'hFFFFFFF3, 32'hC);
        addVec(1, 1, 1, 10'd7, 1, 1, 32'hFFFFFFEF, 32'h10);
        addVec(1, 1, 1, 10'd8, 1, 1, 32'hFFFFFFEB, 32'h14);
        addVec(1, 1, 1, 10'd9, 1, 1, 32'hFFFFFFE7, 32'h18);

        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i].rst_n, 1'b0, 32'h0, vq[i].ready);
            checkOutput($sformatf("vec%0d_rd_en", i), bus.ibus_rd_en, vq[i].exp_rd_en);
            checkOutput($sformatf("vec%0d_addr", i), bus.ibus_rd_addr, vq[i].exp_addr);
            checkOutput($sformatf("vec%0d_valid", i), bus.inst_valid, vq[i].exp_valid);
            if (vq[i].chk_head) begin
                checkOutput($sformatf("vec%0d_inst", i), bus.inst, vq[i].exp_inst);
                checkOutput($sformatf("vec%0d_pc", i), bus.inst_pc, vq[i].exp_pc);
                checkOutput($sformatf("vec%0d_af", i), bus.access_fault, 1'b0);
                checkOutput($sformatf("vec%0d_mis", i), bus.misaligned, 1'b0);
            end
        end

        // ---------------- flush while loaded with a read in flight ----------------
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0);
        checkOutput("full_no_issue", bus.ibus_rd_en, 1'b0);
        checkHead("full_head", 32'hFFFFFFE3, 32'h1C, 0, 0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("freed_slot_no_issue", bus.ibus_rd_en, 1'b0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("refill_issue", bus.ibus_rd_en, 1'b1);
        checkOutput("refill_addr", bus.ibus_rd_addr, 10'h0B);
        applyStimulus(1, 1, 32'h100, 1);
        checkOutput("redir_no_issue", bus.ibus_rd_en, 1'b0);
        applyStimulus(1, 0, 0, 1);
        checkEmpty("redir_t1");
        checkOutput("redir_t1_rd_en", bus.ibus_rd_en, 1'b1);
        checkOutput("redir_t1_addr", bus.ibus_rd_addr, 10'h40);
        applyStimulus(1, 0, 0, 1);
        checkOutput("redir_t2_valid", bus.inst_valid, 1'b0);
        checkOutput("redir_t2_addr", bus.ibus_rd_addr, 10'h41);
        applyStimulus(1, 0, 0, 1);
        checkHead("redir_t3", 32'hFFFFFEFF, 32'h100, 0, 0);
        applyStimulus(1, 0, 0, 1);
        checkHead("redir_t4", 32'hFFFFFEFB, 32'h104, 0, 0);

        // ---------------- access fault and halt ----------------
        applyStimulus(1, 1, 32'h1000, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("af_t1_rd_en", bus.ibus_rd_en, 1'b0);
        checkOutput("af_t1_valid", bus.inst_valid, 1'b0);
        applyStimulus(1, 0, 0, 0);
        checkHead("af_entry", 32'h0, 32'h1000, 1, 0);
        checkOutput("af_t2_rd_en", bus.ibus_rd_en, 1'b0);
        applyStimulus(1, 0, 0, 1);
        checkHead("af_entry_pop", 32'h0, 32'h1000, 1, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 1);
            checkOutput($sformatf("halt%0d_valid", i), bus.inst_valid, 1'b0);
            checkOutput($sformatf("halt%0d_rd_en", i), bus.ibus_rd_en, 1'b0);
        end

        // ---------------- misaligned redirect ----------------
        applyStimulus(1, 1, 32'h102, 1);
        applyStimulus(1, 0, 0, 1);
`ifdef IFETCH_MISALIGN_EN
        checkOutput("mis_t1_rd_en", bus.ibus_rd_en, 1'b0);
        applyStimulus(1, 0, 0, 1);
        checkHead("mis_entry", 32'h0, 32'h102, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("mis_halt_valid", bus.inst_valid, 1'b0);
        checkOutput("mis_halt_rd_en", bus.ibus_rd_en, 1'b0);
`else
        checkOutput("mis_t1_rd_en", bus.ibus_rd_en, 1'b1);
        checkOutput("mis_t1_addr", bus.ibus_rd_addr, 10'h40);
        applyStimulus(1, 0, 0, 1);
        checkOutput("mis_t2_addr", bus.ibus_rd_addr, 10'h41);
        applyStimulus(1, 0, 0, 1);
        checkHead("mis_entry", 32'hFFFFFEFF, 32'h102, 0, 0);
        applyStimulus(1, 0, 0, 1);
        checkHead("mis_next", 32'hFFFFFEFB, 32'h106, 0, 0);
`endif

        // ---------------- reset while full ----------------
        applyStimulus(1, 1, 32'h200, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0);
        checkHead("prerst_head", 32'hFFFFFDFF, 32'h200, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("rst_rd_en", bus.ibus_rd_en, 1'b0);
        applyStimulus(1, 0, 0, 1);
        checkEmpty("postrst");
        checkOutput("postrst_rd_en", bus.ibus_rd_en, 1'b1);
        checkOutput("postrst_addr", bus.ibus_rd_addr, 10'h0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("postrst_c1_valid", bus.inst_valid, 1'b0);
        applyStimulus(1, 0, 0, 1);
        checkHead("postrst_c2", 32'hFFFFFFFF, 32'h0, 0, 0);

        // ---------------- randomized stream vs reference model ----------------
        applyStimulus(1, 1, 32'h0, 0);
        mFetch = 32'h0; mPop = 32'h0; outstanding = 0;
        halted = 0; idle = 0; pops = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        redir;
            logic [31:0] rpc;
            logic        rdy;
            redir = ($urandom_range(0, 29) == 0);
            rpc   = pickTarget();
            rdy   = ($urandom_range(0, 3) != 0);
            applyStimulus(1, redir, rpc, rdy);
            if (redir) begin
                checkOutput("rnd_redir_no_issue", bus.ibus_rd_en, 1'b0);
                mFetch = rpc; mPop = rpc; outstanding = 0; halted = 0; idle = 0;
                continue;
            end
            if (bus.ibus_rd_en) begin
                checkOutput("rnd_issue_legal",
                            !isAf(mFetch) && !isMis(mFetch) && outstanding < DEPTH, 1'b1);
                checkOutput("rnd_issue_addr", bus.ibus_rd_addr, (mFetch / 4) % 1024);
                mFetch = mFetch + 4;
                outstanding++;
            end
            if (halted) begin
                checkOutput("rnd_halt_quiet", bus.inst_valid, 1'b0);
            end else if (bus.inst_valid) begin
                idle = 0;
                if (rdy) begin
                    pops++;
                    if (isAf(mPop) || isMis(mPop)) begin
                        checkHead("rnd_fault", 32'h0, mPop, isAf(mPop), isMis(mPop));
                        halted = 1;
                    end else begin
                        checkHead("rnd_pop", ~(mPop & 32'hFFFFFFFC), mPop, 0, 0);
                        mPop = mPop + 4;
                        outstanding--;
                    end
                end
            end else begin
                idle++;
                if (idle >= 4) begin
                    checkOutput("rnd_starved", bus.inst_valid, 1'b1);
                    idle = 0;
                end
            end
        end
        checkOutput("rnd_enough_pops", pops > 200, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
